// File: rtl/usb_tx_scheduler_pkg.sv
// Shared types and constants for the USB transmit-path scheduler.
package usb_tx_pkg;

   localparam int PKT_W = 100;   // packet width into the CRC calculator
   localparam int LEN_W = 32;    // packet length width

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_START,
      ST_SENDING,
      ST_GAP
   } tx_sched_state_t;

   // Largest of three values, used to size the shared counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/usb_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active request searching upward
// (wrapping) from the slot after the last winner. Purely combinational.
module rr_arbiter #(
   parameter int N = 3,
   localparam int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_winner
);

   logic [PTR_W:0] w_idx;
   logic           w_found;

   // Walk the N candidates starting at ptr+1; the first set request wins.
   always_comb begin
      o_winner = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = {1'b0, i_ptr} + (PTR_W+1)'(k);
         if (w_idx >= (PTR_W+1)'(N)) begin
            w_idx = w_idx - (PTR_W+1)'(N);
         end
         if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
            o_winner[w_idx[PTR_W-1:0]] = 1'b1;
            w_found                    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Shares the CRC + bit-stuffer transmit path among NUM_REQ packet sources.
// Grants one source round-robin, latches its packet, strobes the CRC block,
// follows the bit stuffer's busy flag, then holds an inter-packet gap.
module usb_tx_scheduler #(
   parameter int NUM_REQ  = 3,
   parameter int PKT_W    = usb_tx_pkg::PKT_W,
   parameter int GAP_CYC  = 4,
   parameter int START_TO = 16,
   parameter int XFER_TO  = 256
) (
   input  logic                                 i_clock,
   input  logic                                 i_reset_n,
   input  logic [NUM_REQ-1:0]                   i_req,
   input  logic [NUM_REQ*PKT_W-1:0]             i_req_pkt,
   input  logic [NUM_REQ*usb_tx_pkg::LEN_W-1:0] i_req_len,
   output logic [NUM_REQ-1:0]                   o_grant,
   output logic [NUM_REQ-1:0]                   o_done,
   output logic [NUM_REQ-1:0]                   o_err,
   output logic                                 o_pkt_ready,
   output logic [PKT_W-1:0]                     o_pkt_in,
   output logic [usb_tx_pkg::LEN_W-1:0]         o_pkt_len,
   input  logic                                 i_bs_sending,
   output logic                                 o_busy
);

   import usb_tx_pkg::*;

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(max3(START_TO, XFER_TO, GAP_CYC) + 1);

   // Terminal counts; a zero-length gap still spends one cycle in GAP.
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
   localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TO - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

   tx_sched_state_t     r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [PTR_W-1:0]    r_ptr;
   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  r_done;
   logic [NUM_REQ-1:0]  r_err;
   logic                r_pkt_ready;
   logic [PKT_W-1:0]    r_pkt_in;
   logic [LEN_W-1:0]    r_pkt_len;
   logic                r_busy;

   logic [NUM_REQ-1:0]  w_win;
   logic [PTR_W-1:0]    w_win_idx;
   logic [PKT_W-1:0]    w_pkt_slice [NUM_REQ];
   logic [LEN_W-1:0]    w_len_slice [NUM_REQ];

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_winner (w_win)
   );

   // Unpack the flat per-source buses.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_pkt_slice[gi] = i_req_pkt[gi*PKT_W +: PKT_W];
      assign w_len_slice[gi] = i_req_len[gi*LEN_W +: LEN_W];
   end

   // One-hot winner to index, for the latch mux and the rr pointer.
   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win[i]) begin
            w_win_idx = PTR_W'(i);
         end
      end
   end

   // Scheduler FSM with the shared start/transfer/gap counter and packet latches.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_ptr       <= PTR_W'(NUM_REQ - 1);
         r_grant     <= '0;
         r_done      <= '0;
         r_err       <= '0;
         r_pkt_ready <= 1'b0;
         r_pkt_in    <= '0;
         r_pkt_len   <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_pkt_ready <= 1'b0;
         r_done      <= '0;
         r_err       <= '0;
         case (r_state)
            ST_IDLE: begin
               if (|i_req) begin
                  r_grant     <= w_win;
                  r_pkt_in    <= w_pkt_slice[w_win_idx];
                  r_pkt_len   <= w_len_slice[w_win_idx];
                  r_ptr       <= w_win_idx;
                  r_pkt_ready <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_cnt   <= '0;
               r_state <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (i_bs_sending) begin
                  r_cnt   <= '0;
                  r_state <= ST_SENDING;
               end else if (r_cnt == START_LAST) begin
                  r_err   <= r_grant;
                  r_cnt   <= '0;
                  r_state <= ST_GAP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_SENDING: begin
               if (!i_bs_sending) begin
                  r_done  <= r_grant;
                  r_cnt   <= '0;
                  r_state <= ST_GAP;
               end else if (r_cnt == XFER_LAST) begin
                  r_err   <= r_grant;
                  r_cnt   <= '0;
                  r_state <= ST_GAP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_grant     = r_grant;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_pkt_ready = r_pkt_ready;
   assign o_pkt_in    = r_pkt_in;
   assign o_pkt_len   = r_pkt_len;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Randomized bench for usb_tx_scheduler with a transaction-level reference:
// owner from a round-robin search, outcome and timing from arithmetic on the
// bit-stuffer activity the bench itself drives.
module tb_usb_tx_scheduler;

   localparam int NUM_REQ  = 3;
   localparam int PKT_W    = 100;
   localparam int LEN_W    = 32;
   localparam int GAP_CYC  = 4;
   localparam int START_TO = 16;
   localparam int XFER_TO  = 256;
   localparam int GAP_LEN  = (GAP_CYC == 0) ? 1 : GAP_CYC;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*PKT_W-1:0] req_pkt;
   logic [NUM_REQ*LEN_W-1:0] req_len;
   logic                     bs;
   logic [NUM_REQ-1:0]       grant, done, err;
   logic                     pkt_ready, busy;
   logic [PKT_W-1:0]         pkt_in;
   logic [LEN_W-1:0]         pkt_len;

   // Reference state: per-source packets, pending packet counts, rr pointer.
   logic [PKT_W-1:0] pkt_m [NUM_REQ];
   logic [LEN_W-1:0] len_m [NUM_REQ];
   int               pending [NUM_REQ];
   int               ptr_m;
   int               n_cmp = 0;
   int               n_bad = 0;

   usb_tx_scheduler #(
      .NUM_REQ (NUM_REQ), .PKT_W (PKT_W), .GAP_CYC (GAP_CYC),
      .START_TO (START_TO), .XFER_TO (XFER_TO)
   ) dut (
      .i_clock      (clk),
      .i_reset_n    (reset_n),
      .i_req        (req),
      .i_req_pkt    (req_pkt),
      .i_req_len    (req_len),
      .o_grant      (grant),
      .o_done       (done),
      .o_err        (err),
      .o_pkt_ready  (pkt_ready),
      .o_pkt_in     (pkt_in),
      .o_pkt_len    (pkt_len),
      .i_bs_sending (bs),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] onehot(input int w);
      return NUM_REQ'(1) << w;
   endfunction

   // Reference arbitration: first set request searching upward from p+1.
   function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic logic [PKT_W-1:0] rand_pkt();
      logic [PKT_W-1:0] p;
      for (int b = 0; b < PKT_W; b++) p[b] = 1'($urandom_range(0, 1));
      return p;
   endfunction

   task automatic pack_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_pkt[i*PKT_W +: PKT_W] = pkt_m[i];
         req_len[i*LEN_W +: LEN_W] = len_m[i];
      end
   endtask

   task automatic refresh(input int i);
      pkt_m[i] = rand_pkt();
      len_m[i] = 32'($urandom_range(1, 1000));
      pack_inputs();
   endtask

   task automatic set_req();
      for (int i = 0; i < NUM_REQ; i++) req[i] = (pending[i] > 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      bs      = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ptr_m   = NUM_REQ - 1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_grant"}, grant, '0);
      check_val({tag, "_done"}, done, '0);
      check_val({tag, "_err"}, err, '0);
      check_val({tag, "_pkt_ready"}, pkt_ready, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_pkt_in"}, pkt_in, '0);
      check_val({tag, "_pkt_len"}, pkt_len, '0);
   endtask

   // One packet, called at a sample point where the DUT is idle and req is driven.
   task automatic xfer(input bit start, input int d, input int len);
      int w, n, e_off, got_pulses, extra_ready;
      bit drop, is_err;
      logic [PKT_W-1:0] exp_pkt;
      logic [LEN_W-1:0] exp_len;
      w       = rr_pick(req, ptr_m);
      exp_pkt = pkt_m[w];
      exp_len = len_m[w];
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pkt_ready && n < 8);
      check_val("pkt_ready_latency", n, 1);
      check_val("grant_owner", grant, onehot(w));
      check_val("pkt_in_latched", pkt_in, exp_pkt);
      check_val("pkt_len_latched", pkt_len, exp_len);
      ptr_m = w;
      // Sources change their buses after the load; the latch must not follow.
      for (int i = 0; i < NUM_REQ; i++) refresh(i);
      if (!start) begin
         e_off  = START_TO + 1;
         is_err = 1'b1;
      end else if (len <= XFER_TO) begin
         e_off  = d + len + 1;
         is_err = 1'b0;
      end else begin
         e_off  = d + XFER_TO + 1;
         is_err = 1'b1;
      end
      drop        = start && ($urandom_range(0, 2) == 0);
      got_pulses  = 0;
      extra_ready = 0;
      for (int off = 1; off <= e_off + GAP_LEN; off++) begin
         @(negedge clk);
         got_pulses  += ((|done) ? 1 : 0) + ((|err) ? 1 : 0);
         extra_ready += pkt_ready ? 1 : 0;
         if (off == e_off) begin
            check_val("done_vec", done, is_err ? '0 : onehot(w));
            check_val("err_vec", err, is_err ? onehot(w) : '0);
            check_val("busy_at_end", busy, 1);
            pending[w]--;
            refresh(w);
            set_req();
            bs = 1'b0;
         end
         if (off == e_off + GAP_LEN - 1) check_val("grant_in_gap", grant, onehot(w));
         if (off == e_off + GAP_LEN) begin
            check_val("grant_dropped", grant, '0);
            check_val("busy_dropped", busy, 0);
            check_val("pkt_in_stable", pkt_in, exp_pkt);
         end
         if (start && off == d) bs = 1'b1;
         if (start && off == d + len) bs = 1'b0;
         if (drop && off == 2) req[w] = 1'b0;
      end
      check_val("pulse_count", got_pulses, 1);
      check_val("no_extra_pkt_ready", extra_ready, 0);
      $display("xfer owner=%0d start=%0d d=%0d len=%0d drop=%0d outcome=%s at +%0d",
               w, start, d, len, drop, is_err ? "err" : "done", e_off);
   endtask

   // Serve every pending packet; mode selects the bit-stuffer behaviour.
   task automatic run_queue(input int mode);
      bit start;
      int d, len, r, guard;
      set_req();
      guard = 0;
      while (req != '0 && guard < 40) begin
         guard++;
         start = 1'b1;
         d     = $urandom_range(1, START_TO);
         len   = $urandom_range(1, 40);
         case (mode)
            1: start = 1'b0;
            2: begin d = $urandom_range(1, 4); len = XFER_TO + 10; end
            3: begin
               r = $urandom_range(0, 5);
               case (r)
                  0: len = XFER_TO;
                  1: len = XFER_TO + 1;
                  2: start = 1'b0;
                  3: d = START_TO;
                  default: ;
               endcase
            end
            4: begin d = 2; len = 25; end
            default: ;
         endcase
         xfer(start, d, len);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      req     = '0;
      bs      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pkt_m[i]   = '0;
         len_m[i]   = '0;
         pending[i] = 0;
      end
      pack_inputs();
      do_reset();
      check_idle_outputs("reset");

      // Single source, fixed packet, 25-cycle transmission.
      pending[0] = 1;
      pkt_m[0]   = PKT_W'(19'b0100_0000101_11100001);
      len_m[0]   = 32'd19;
      pack_inputs();
      run_queue(4);

      // All three requesting from reset: order 0,1,2,0.
      do_reset();
      pending[0] = 2; pending[1] = 1; pending[2] = 1;
      for (int i = 0; i < NUM_REQ; i++) refresh(i);
      run_queue(0);

      // Bit stuffer never starts.
      pending[0] = 1; pending[1] = 1;
      run_queue(1);

      // Bit stuffer stuck high.
      pending[2] = 1;
      run_queue(2);

      // Reset while a packet is in SENDING.
      pending[1] = 1;
      refresh(1);
      set_req();
      begin
         int n;
         n = 0;
         do begin @(negedge clk); n++; end while (!pkt_ready && n < 8);
         check_val("rst_mid_pkt_ready", n, 1);
         bs = 1'b1;
         repeat (6) @(negedge clk);
         check_val("rst_mid_busy_before", busy, 1);
         reset_n = 1'b0;
         req     = '0;
         bs      = 1'b0;
         pending[1] = 0;
         @(negedge clk);
         reset_n = 1'b1;
         ptr_m   = NUM_REQ - 1;
         check_idle_outputs("rst_mid");
         repeat (3) @(negedge clk);
         check_val("rst_mid_no_done", done, '0);
         check_val("rst_mid_no_err", err, '0);
         check_val("rst_mid_idle", busy, 0);
      end

      // Randomized mixes including timeout boundaries.
      repeat (4) begin
         for (int i = 0; i < NUM_REQ; i++) pending[i] = $urandom_range(0, 2);
         run_queue(3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
